// File: rtl/mean_square_accumulator_pkg.sv
// Shared widths and types for the RMS path (mean-square and square-root stages).
package mean_square_accumulator_pkg;

  localparam int SAMPLE_W = 8;
  localparam int SQ_W     = 2 * SAMPLE_W - 1;
  localparam int OUT_W    = 8;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic        [SQ_W-1:0]     square_t;
  typedef logic        [OUT_W-1:0]    result_t;

endpackage

// File: rtl/mean_square_accumulator_square_stage.sv
// Registered signed squarer with valid bit, hold-enable and synchronous flush.
module square_stage
  import mean_square_accumulator_pkg::*;
(
  input  logic    i_clk,
  input  logic    i_reset_n,
  input  logic    i_en,
  input  logic    i_accept,
  input  logic    i_clear,
  input  sample_t i_data,
  output square_t o_sq,
  output logic    o_sq_v
);

  square_t sq_p1;
  logic    vld_p1;

  // (-128)^2 = 16384 is the only square that needs bit 14, so the product fits SQ_W unsigned.
  function automatic square_t square_mag(input sample_t d);
    logic signed [2*SAMPLE_W-1:0] p;
    p = d * d;
    return SQ_W'(p);
  endfunction

  // Stage 1: square
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      vld_p1 <= 1'b0;
      sq_p1  <= '0;
    end else if (i_clear) begin
      vld_p1 <= 1'b0;
    end else if (i_en) begin
      vld_p1 <= i_accept;
      if (i_accept) begin
        sq_p1 <= square_mag(i_data);
      end
    end
  end

  assign o_sq   = sq_p1;
  assign o_sq_v = vld_p1;

endmodule

// File: rtl/mean_square_accumulator.sv
// Block mean-square of signed samples over 2^LOG2_N-sample windows, valid/ready output.
module mean_square_accumulator
  import mean_square_accumulator_pkg::*;
#(
  parameter int LOG2_N = 4
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic signed [SAMPLE_W-1:0] i_data,
  input  logic             i_clear,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [OUT_W-1:0] o_data
);

  localparam int N     = 1 << LOG2_N;
  localparam int ACC_W = SQ_W + LOG2_N;
  localparam int CNT_W = (LOG2_N == 0) ? 1 : LOG2_N;
  localparam int SHIFT = LOG2_N + 7;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  logic             en;
  logic             accept;
  square_t          sq_p1;
  logic             vld_p1;
  logic [ACC_W-1:0] acc_p2;
  logic [CNT_W-1:0] cnt_p2;
  logic [ACC_W-1:0] sum_p2;
  logic             last_p2;

  // Dividing by N and by 2^7 maps a full-scale window (N * 16384) onto 128; truncation only.
  function automatic result_t scale_trunc(input logic [ACC_W-1:0] s);
    logic [ACC_W-1:0] sh;
    sh = s >> SHIFT;
    return OUT_W'(sh);
  endfunction

  assign en      = !o_valid || i_ready;
  assign o_ready = en;
  assign accept  = i_valid && en && !i_clear;

  square_stage u_square (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_en      (en),
    .i_accept  (accept),
    .i_clear   (i_clear),
    .i_data    (i_data),
    .o_sq      (sq_p1),
    .o_sq_v    (vld_p1)
  );

  assign sum_p2  = acc_p2 + ACC_W'(sq_p1);
  assign last_p2 = (cnt_p2 == CNT_LAST);

  // Stage 2: accumulate and load output register
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      acc_p2  <= '0;
      cnt_p2  <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
    end else begin
      if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
      if (i_clear) begin
        acc_p2 <= '0;
        cnt_p2 <= '0;
      end else if (en && vld_p1) begin
        if (last_p2) begin
          o_data  <= scale_trunc(sum_p2);
          o_valid <= 1'b1;
          acc_p2  <= '0;
          cnt_p2  <= '0;
        end else begin
          acc_p2 <= sum_p2;
          cnt_p2 <= cnt_p2 + 1'b1;
        end
      end
    end
  end

endmodule
